// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the AXI-Stream to UART emitter.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CR,
    ST_LF
  } state_e;

  // Which producer loaded the frame now on the line.
  typedef enum logic [1:0] {
    SRC_FIFO,
    SRC_CR,
    SRC_LF
  } src_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  // Rounded clock-per-bit divisor.
  function automatic int calc_div(input int clk_hz, input int baud);
    return int'((longint'(clk_hz) + longint'(baud) / 2) / longint'(baud));
  endfunction

endpackage

// File: rtl/uart_stream_fifo.sv
// Register-based synchronous FIFO of {tlast,tdata} entries with occupancy outputs.
module uart_stream_fifo
  import uart_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  fifo_entry_t   wdata_i,
  input  logic          pop_i,
  output fifo_entry_t   rdata_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_nxt_o,
  output logic          empty_o,
  output logic          full_o
);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty_o     = (level_q == '0);
  assign full_o      = (level_q == LW'(DEPTH));
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign rdata_o     = mem_q[rptr_q];
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_stream_emitter.sv
// AXI-Stream byte source to 8N1/8N2 UART line, with elastic FIFO and optional CR/LF after tlast.
module uart_stream_emitter
  import uart_stream_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int BAUD        = 57600,
  parameter int DEPTH       = 16,
  parameter int STOP_BITS   = 1,
  parameter int TLAST_CRLF  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   o_tready,
  output logic                   o_uart_tx,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy
);

  localparam int DIV      = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int STOP_CYC = STOP_BITS * DIV;
  localparam int CW       = $clog2(STOP_CYC);
  localparam int LW       = $clog2(DEPTH) + 1;

  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("uart_stream_emitter: baud divisor %0d out of range 2..65535", DIV);
  end
  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_stream_emitter: DEPTH %0d must be a power of two in 2..1024", DEPTH);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_stream_emitter: STOP_BITS %0d must be 1 or 2", STOP_BITS);
  end

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  logic          last_q, last_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          tready_q;

  fifo_entry_t   wdata, rdata;
  logic [LW-1:0] level, level_nxt;
  logic          fifo_empty, fifo_full, push, pop;

  assign wdata = '{last: i_tlast, data: i_tdata};
  assign push  = i_tvalid && tready_q && !fifo_full;

  uart_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .push_i      (push),
    .wdata_i     (wdata),
    .pop_i       (pop),
    .rdata_o     (rdata),
    .level_o     (level),
    .level_nxt_o (level_nxt),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = rdata.data;
          last_d  = rdata.last;
          src_d   = SRC_FIFO;
          cnt_d   = CW'(DIV - 1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = CW'(DIV - 1);
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          if (bit_q == 3'd7) begin
            cnt_d   = CW'(STOP_CYC - 1);
            state_d = ST_STOP;
          end else begin
            cnt_d   = CW'(DIV - 1);
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (src_q == SRC_CR)
            state_d = ST_LF;
          else if (src_q == SRC_FIFO && last_q && TLAST_CRLF != 0)
            state_d = ST_CR;
          else
            state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      // Trailer frames take the same single setup cycle as a FIFO pop.
      ST_CR: begin
        shift_d = CR_BYTE;
        src_d   = SRC_CR;
        cnt_d   = CW'(DIV - 1);
        state_d = ST_START;
      end
      ST_LF: begin
        shift_d = LF_BYTE;
        src_d   = SRC_LF;
        cnt_d   = CW'(DIV - 1);
        state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_FIFO;
      last_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      last_q   <= last_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      tready_q <= (level_nxt < LW'(DEPTH));
    end
  end

  assign o_tready  = tready_q;
  assign o_uart_tx = tx_q;
  assign o_level   = level;
  assign o_busy    = (state_q != ST_IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_stream_emitter.sv
// Three emitter configurations driven from one stimulus thread; a line decoder per instance checks bytes against a push-time scoreboard.
module tb_uart_stream_emitter;

  logic       clk;
  logic [2:0] rst_n;
  logic [7:0] tdata [3];
  logic [2:0] tlast;
  logic [2:0] tvalid;
  wire  [2:0] tready;
  wire  [2:0] tx;
  wire  [2:0] busy;
  logic [4:0] level [3];

  logic [7:0] exp_q [3][$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // g0: DIV 16, 1 stop, CRLF on, depth 16.  g1: DIV 16, 2 stop, CRLF off.  g2: DIV 4, CRLF on, depth 4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DP   = (g == 2) ? 4 : 16;
    localparam int LW   = $clog2(DP) + 1;
    localparam int SB   = (g == 1) ? 2 : 1;
    localparam int CRLF = (g == 1) ? 0 : 1;
    localparam int DV   = (g == 2) ? 4 : 16;
    localparam int FR   = (9 + SB) * DV;
    logic [LW-1:0] lvl;

    uart_stream_emitter #(
      .CLK_FREQ_HZ (16_000_000),
      .BAUD        ((g == 2) ? 4_000_000 : 1_000_000),
      .DEPTH       (DP),
      .STOP_BITS   (SB),
      .TLAST_CRLF  (CRLF)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n[g]),
      .i_tdata   (tdata[g]),
      .i_tlast   (tlast[g]),
      .i_tvalid  (tvalid[g]),
      .o_tready  (tready[g]),
      .o_uart_tx (tx[g]),
      .o_level   (lvl),
      .o_busy    (busy[g])
    );

    assign level[g] = 5'(lvl);

    always @(posedge clk) begin
      if (rst_n[g] && tvalid[g] && tready[g]) begin
        exp_q[g].push_back(tdata[g]);
        if (tlast[g] && CRLF != 0) begin
          exp_q[g].push_back(8'h0D);
          exp_q[g].push_back(8'h0A);
        end
      end
    end

    // Line decoder: samples every cycle of a frame against the ideal waveform.
    initial begin
      logic [7:0] b, e;
      logic want;
      int bad, seg;
      bit chain, abort, pend, known;
      chain = 1'b0;
      forever begin
        if (!chain) begin
          @(negedge clk);
          while (!(rst_n[g] && tx[g] == 1'b0)) @(negedge clk);
        end
        chain = 1'b0; abort = 1'b0; bad = 0; b = '0; e = '0;
        known = (exp_q[g].size() != 0);
        chk("rx_frame_expected", known, 1);
        if (known) e = exp_q[g].pop_front();
        for (int s = 0; s < FR; s++) begin
          if (s != 0) @(negedge clk);
          if (!rst_n[g]) begin
            abort = 1'b1;
            break;
          end
          seg = s / DV;
          if (seg == 0)      want = 1'b0;
          else if (seg <= 8) want = e[3'(seg - 1)];
          else               want = 1'b1;
          if (tx[g] !== want) bad++;
          if (seg >= 1 && seg <= 8 && (s % DV) == DV / 2) b[3'(seg - 1)] = tx[g];
          if (s == FR - 2) chk("rx_busy_in_stop", busy[g], 1);
        end
        if (!abort && known) begin
          chk("rx_byte", b, e);
          chk("rx_bit_timing_errors", bad, 0);
          pend = (exp_q[g].size() != 0);
          @(negedge clk);
          if (rst_n[g]) begin
            chk("rx_gap_high", tx[g], 1);
            if (pend) begin
              @(negedge clk);
              chk("rx_gap_one_cycle", tx[g], 0);
              chain = rst_n[g] && (tx[g] == 1'b0);
            end else if (exp_q[g].size() == 0) begin
              chk("rx_busy_after_stop", busy[g], 0);
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d, input logic l, input int stall);
    int n;
    while ($urandom_range(0, 99) < stall) @(negedge clk);
    tdata[g]  = d;
    tlast[g]  = l;
    tvalid[g] = 1'b1;
    n = 0;
    while (!tready[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", tready[g], 1);
    @(negedge clk);
    tvalid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while ((exp_q[g].size() != 0 || busy[g]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 20000, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n  = '0;
    tvalid = '0;
    tlast  = '0;
    for (int g = 0; g < 3; g++) tdata[g] = 8'h00;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_tx", tx[g], 1);
      chk("rst_tready", tready[g], 0);
      chk("rst_level", level[g], 0);
      chk("rst_busy", busy[g], 0);
    end
    rst_n = '1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk("rel_tready", tready[g], 1);

    // Single byte latency: accept edge k, pop k+1, line low from k+2.
    send(0, 8'h55, 1'b0, 0);
    chk("t55_level_k", level[0], 1);
    chk("t55_tx_k", tx[0], 1);
    chk("t55_busy_k", busy[0], 1);
    @(negedge clk);
    chk("t55_level_k1", level[0], 0);
    chk("t55_tx_k1", tx[0], 1);
    @(negedge clk);
    chk("t55_tx_k2", tx[0], 0);
    wait_idle(0);

    // Two stop bits, back-to-back frames.
    send(1, 8'hA5, 1'b0, 0);
    send(1, 8'h3C, 1'b0, 0);
    wait_idle(1);

    // "OK" with tlast on K: trailer only where CRLF is enabled.
    send(0, 8'h4F, 1'b0, 0);
    send(0, 8'h4B, 1'b1, 0);
    send(1, 8'h4F, 1'b0, 0);
    send(1, 8'h4B, 1'b1, 0);
    wait_idle(0);
    wait_idle(1);

    // Burst of 20 into a 16-deep FIFO with tvalid held.
    send(0, 8'h00, 1'b0, 0);
    k = cyc;
    for (int i = 1; i <= 16; i++) send(0, 8'(i), 1'b0, 0);
    chk("burst_accept_run", cyc - k, 16);
    chk("burst_full_level", level[0], 16);
    chk("burst_full_tready", tready[0], 0);
    for (int i = 17; i < 20; i++) send(0, 8'(i), 1'b0, 0);
    wait_idle(0);

    // Push coinciding with pop at level 3.
    send(0, 8'hC1, 1'b0, 0);
    k = cyc;
    send(0, 8'hC2, 1'b0, 0);
    send(0, 8'hC3, 1'b0, 0);
    send(0, 8'hC4, 1'b0, 0);
    chk("pp_level_fill", level[0], 3);
    while (cyc < k + 1 + 160) @(negedge clk);
    chk("pp_level_before", level[0], 3);
    send(0, 8'hC5, 1'b0, 0);
    chk("pp_edge", cyc, k + 2 + 160);
    chk("pp_level_same", level[0], 3);
    wait_idle(0);

    // Reset mid-frame with bytes queued.
    send(1, 8'hFF, 1'b0, 0);
    for (int i = 0; i < 5; i++) send(1, 8'(8'h61 + i), 1'b0, 0);
    repeat (40) @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("mid_rst_tx", tx[1], 1);
    chk("mid_rst_tready", tready[1], 0);
    chk("mid_rst_level", level[1], 0);
    chk("mid_rst_busy", busy[1], 0);
    exp_q[1].delete();
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", tready[1], 1);
    chk("post_rst_level", level[1], 0);
    repeat (400) @(negedge clk);
    chk("post_rst_tx_idle", tx[1], 1);
    chk("post_rst_busy", busy[1], 0);

    // Random traffic with 30% upstream stalls on the fast, shallow instance.
    for (int i = 0; i < 500; i++)
      send(2, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 30);
    wait_idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_stream_emitter.md
# uart_stream_emitter

Parametrised successor of the byte-stream-to-UART emitter used by the corescore board tops. Accepts an 8-bit AXI-Stream (tdata/tlast/tvalid/tready) from the core aggregator and serialises it as 8N1/8N2 UART frames. It adds an elastic FIFO of configurable depth, a baud divisor derived from parameters, selectable stop bits and optional CR/LF insertion after each tlast byte. Sits between `corescorecore` and the board TX pin.

## Interface
- `CLK_FREQ_HZ`, 16_000_000, input clock frequency.
- `BAUD`, 57600, line rate; DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD, elaboration error if DIV < 2 or DIV > 65535.
- `DEPTH`, 16, FIFO entries; power of two, 2..1024, else elaboration error.
- `STOP_BITS`, 1, 1 or 2.
- `TLAST_CRLF`, 0, 1 = emit 0x0D then 0x0A after every byte whose tlast was set.
- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_tdata`  in  8  stream byte.
- `i_tlast`  in  1  end-of-message marker.
- `i_tvalid`  in  1  byte valid.
- `o_tready`  out  1  FIFO can accept.
- `o_uart_tx`  out  1  serial line, idle high.
- `o_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `o_busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- Reset (asserted, async): `o_uart_tx`=1, `o_tready`=0, `o_level`=0, `o_busy`=0, FIFO flushed, FSM IDLE, counters 0. Reset mid-frame aborts the frame; line returns high immediately, no completion.
- `o_tready` registered; becomes 1 on the first rising edge after `i_rst_n` rises; thereafter `o_tready` = (level < DEPTH), updated each edge from next-state level.
- Push: `i_tvalid && o_tready` at edge stores {tlast,tdata} (9 bits). Pop: FSM in IDLE and FIFO non-empty. Push and pop on same edge: level unchanged. Push never occurs when full (tready=0); data presented with tvalid while tready=0 is held by upstream, not dropped.
- FSM states: IDLE, START, DATA, STOP, CR, LF.
  - IDLE: if non-empty, pop, load shift register, -> START.
  - START: line 0 for DIV cycles -> DATA.
  - DATA: 8 bits LSB first, DIV cycles each -> STOP.
  - STOP: line 1 for STOP_BITS*DIV cycles. Exit: if current byte had tlast and TLAST_CRLF and byte source was FIFO -> CR; if source was CR-frame -> LF; else -> IDLE.
  - CR/LF: load 0x0D / 0x0A, -> START (source tag recorded). After LF's STOP -> IDLE.
- Baud counter counts DIV-1 down to 0; bit index 0..7 wraps nowhere (frame ends at 7).
- `o_level` counts 0..DEPTH inclusive; pointers wrap modulo DEPTH.
- `o_busy` = FSM != IDLE || level != 0.

## Timing
- Byte accepted at edge k into empty FIFO with FSM IDLE: pop at edge k+1, `o_uart_tx` falls at edge k+2 (registered output).
- Every bit exactly DIV cycles; frame = (9+STOP_BITS)*DIV cycles.
- Back-to-back FIFO bytes: next start bit begins exactly one cycle after previous stop period ends (one IDLE cycle for pop); no longer gap.
- CRLF frames follow the tlast byte with the same one-cycle gap.
- `o_tready` deasserts on the edge where level reaches DEPTH; reasserts the edge after a pop from full.

## Structure
- Package `uart_stream_pkg`: FSM state enum, `calc_div(clk, baud)` function, CR/LF byte constants.
- Sub-module `uart_stream_fifo`: synchronous FIFO, 9-bit wide, DEPTH entries, async active-low reset, outputs level/empty/full; register-based storage.
- Top holds FSM, baud counter, shift register, tready/line registers.

## Test plan
- Single byte 0x55, CLK_FREQ_HZ=16e6, BAUD=1e6 (DIV=16), STOP_BITS=1: line falls 2 cycles after acceptance, bits 1,0,1,0,1,0,1,0 each 16 cycles, stop high 16, frame 160 cycles.
- Burst of 20 bytes 0x00..0x13 with DEPTH=16, tvalid held: tready drops when level=16, no byte lost or duplicated, frames contiguous with 1-cycle gaps, decoded sequence matches.
- TLAST_CRLF=1: bytes "OK" with tlast on 'K' -> line decodes 0x4F,0x4B,0x0D,0x0A then idle; with TLAST_CRLF=0 -> 0x4F,0x4B only.
- STOP_BITS=2, byte 0xA5: stop period 32 cycles, frame 176 cycles; next frame start no earlier.
- Reset asserted mid-DATA of 0xFF with 5 bytes queued: o_uart_tx=1, o_tready=0, o_level=0 immediately; after release, tready=1 next edge, no residual frame emitted.
- Simultaneous push/pop at level=3: level stays 3; random tvalid stall (30%) over 500 bytes: scoreboard matches, o_busy falls only after last stop bit.
